// File: rtl/fnd_display_arbiter.sv
// Shares the 4-digit FND between the foreground value and four prioritised event requesters.
// Each served requester gets a timed, pre-emptible pop-up that shows its live data.
module fnd_display_arbiter #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int POPUP_SEC   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] base_data,
    input  logic [3:0]  req,
    input  logic [55:0] req_data,
    input  logic [3:0]  req_mask,
    input  logic        btn_dismiss,
    output logic [13:0] seg_data,
    output logic [2:0]  src_sel,
    output logic        popup_active,
    output logic [3:0]  grant
);

    localparam int            PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]    SEC_LAST   = 4'(POPUP_SEC - 1);

    typedef enum logic {ST_BASE, ST_POPUP} state_e;

    state_e        state_q, state_d;
    logic [1:0]    active_q, active_d;
    logic [3:0]    pending_q, pending_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_q, sec_d;
    logic          dismiss_q;
    logic [13:0]   seg_q, seg_d;
    logic [2:0]    src_q, src_d;
    logic          popup_q, popup_d;
    logic [3:0]    grant_q, grant_d;

    logic [13:0]   slot [4];
    logic [3:0]    req_en;
    logic [3:0]    cand;
    logic [1:0]    winner;
    logic          dismiss_edge;
    logic          expire;
    logic          launch;

    for (genvar i = 0; i < 4; i++) begin : g_slot
        assign slot[i] = req_data[i*14 +: 14];
    end

    // Pending bits of disabled requesters never compete.
    assign req_en       = req & req_mask;
    assign cand         = (pending_q & req_mask) | req_en;
    assign dismiss_edge = btn_dismiss & ~dismiss_q;
    assign expire       = (presc_q == PRESC_LAST) && (sec_q == SEC_LAST);

    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) winner = 2'(i);
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d   = state_q;
        active_d  = active_q;
        pending_d = (pending_q | req_en) & req_mask;
        presc_d   = '0;
        sec_d     = '0;
        seg_d     = base_data;
        src_d     = 3'd0;
        popup_d   = 1'b0;
        grant_d   = 4'd0;
        launch    = 1'b0;

        case (state_q)
            ST_BASE: launch = |cand;
            ST_POPUP: begin
                if (dismiss_edge || !req_mask[active_q]) begin
                    state_d = ST_BASE;
                end else begin
                    // The active source is never queued behind itself.
                    pending_d[active_q] = 1'b0;
                    seg_d   = slot[active_q];
                    src_d   = {1'b0, active_q} + 3'd1;
                    popup_d = 1'b1;
                    if ((|cand) && (winner < active_q)) begin
                        launch = 1'b1;
                    end else if (req_en[active_q]) begin
                        grant_d[active_q] = 1'b1;
                    end else if (expire) begin
                        if (|cand) begin
                            launch = 1'b1;
                        end else begin
                            state_d = ST_BASE;
                            seg_d   = base_data;
                            src_d   = 3'd0;
                            popup_d = 1'b0;
                        end
                    end else if (presc_q == PRESC_LAST) begin
                        sec_d = sec_q + 4'd1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                        sec_d   = sec_q;
                    end
                end
            end
            default: state_d = ST_BASE;
        endcase

        if (launch) begin
            state_d           = ST_POPUP;
            active_d          = winner;
            pending_d[winner] = 1'b0;
            grant_d           = 4'b0001 << winner;
            seg_d             = slot[winner];
            src_d             = {1'b0, winner} + 3'd1;
            popup_d           = 1'b1;
            presc_d           = '0;
            sec_d             = '0;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_BASE;
            active_q  <= 2'd0;
            pending_q <= 4'd0;
            presc_q   <= '0;
            sec_q     <= 4'd0;
            dismiss_q <= 1'b0;
            seg_q     <= 14'd0;
            src_q     <= 3'd0;
            popup_q   <= 1'b0;
            grant_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            dismiss_q <= btn_dismiss;
            seg_q     <= seg_d;
            src_q     <= src_d;
            popup_q   <= popup_d;
            grant_q   <= grant_d;
        end
    end

    assign seg_data     = seg_q;
    assign src_sel      = src_q;
    assign popup_active = popup_q;
    assign grant        = grant_q;

endmodule
